// File: rtl/iobus_intr_ctrl.sv
// iobus_intr_ctrl: OTTER IOBUS interrupt controller, sticky edge-pending bits.
// Optional per-source debounce (DB_CYCLES) enabled by INTR_CTRL_DEBOUNCE_EN.
module iobus_intr_ctrl #(
  parameter int unsigned N_SRC     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h1100_0200,
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             RST_N,
  input  logic [N_SRC-1:0] SRC_IN,
  input  logic [31:0]      IOBUS_ADDR,
  input  logic [31:0]      IOBUS_OUT,
  input  logic             IOBUS_WR,
  output logic [31:0]      RD_DATA,
  output logic             RD_HIT,
  output logic             INTR
);

  localparam logic [1:0] SEL_PEND  = 2'd0;
  localparam logic [1:0] SEL_EN    = 2'd1;
  localparam logic [1:0] SEL_CLAIM = 2'd2;
  localparam logic [1:0] SEL_RAW   = 2'd3;

  logic [N_SRC-1:0] r_sync1;
  logic [N_SRC-1:0] r_sync2;
  logic [N_SRC-1:0] r_prev;
  logic [N_SRC-1:0] r_pend;
  logic [N_SRC-1:0] r_en;

  logic [N_SRC-1:0] w_level;
  logic [N_SRC-1:0] w_rise;
  logic [N_SRC-1:0] w_clr;
  logic [N_SRC-1:0] w_act;
  logic [1:0]       w_sel;
  logic             w_wr;
  logic             w_any;
  logic [4:0]       w_idx;
  logic [31:0]      w_claim;

  assign w_sel  = IOBUS_ADDR[3:2];
  assign RD_HIT = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
  assign w_wr   = IOBUS_WR && RD_HIT;

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= SRC_IN;
      r_sync2 <= r_sync1;
    end
  end

`ifdef INTR_CTRL_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DB_CYCLES + 1);

  logic [CW-1:0]    r_db_cnt [N_SRC];
  logic [N_SRC-1:0] r_db_lvl;
  logic             w_unused;

  // level follows sync2 only after DB_CYCLES straight cycles of disagreement
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      r_db_lvl <= '0;
      for (int i = 0; i < N_SRC; i++) r_db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (r_sync2[i] == r_db_lvl[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == CW'(DB_CYCLES - 1)) begin
          r_db_cnt[i] <= '0;
          r_db_lvl[i] <= r_sync2[i];
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_level  = r_db_lvl;
  assign w_unused = ^{IOBUS_ADDR[1:0], IOBUS_OUT};
`else
  logic w_unused;

  assign w_level  = r_sync2;
  assign w_unused = ^{IOBUS_ADDR[1:0], IOBUS_OUT, (DB_CYCLES != 0)};
`endif

  assign w_rise = w_level & ~r_prev;
  assign w_clr  = (w_wr && w_sel == SEL_PEND) ? IOBUS_OUT[N_SRC-1:0] : '0;
  assign w_act  = r_pend & r_en;
  assign w_any  = |w_act;

  // set wins over a same-cycle W1C
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      r_prev <= '0;
      r_pend <= '0;
      r_en   <= '0;
      INTR   <= 1'b0;
    end else begin
      r_prev <= w_level;
      r_pend <= (r_pend & ~w_clr) | w_rise;
      INTR   <= w_any;
      if (w_wr && w_sel == SEL_EN) r_en <= IOBUS_OUT[N_SRC-1:0];
    end
  end

  always_comb begin
    w_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_act[i]) w_idx = 5'(i);
    end
  end

  assign w_claim = {w_any, 26'd0, w_idx};

  always_comb begin
    RD_DATA = '0;
    if (RD_HIT) begin
      unique case (w_sel)
        SEL_PEND:  RD_DATA[N_SRC-1:0] = r_pend;
        SEL_EN:    RD_DATA[N_SRC-1:0] = r_en;
        SEL_CLAIM: RD_DATA = w_claim;
        SEL_RAW:   RD_DATA[N_SRC-1:0] = w_level;
      endcase
    end
  end

endmodule

// File: tb/tb_iobus_intr_ctrl.sv
// tb_iobus_intr_ctrl: directed stimulus with queued expectations;
// a negedge monitor pops and compares whenever a check strobe is raised.
module tb_iobus_intr_ctrl;

  localparam logic [31:0] BASE  = 32'h1100_0200;
  localparam logic [31:0] A_PND = BASE + 32'h0;
  localparam logic [31:0] A_EN  = BASE + 32'h4;
  localparam logic [31:0] A_CLM = BASE + 32'h8;
  localparam logic [31:0] A_RAW = BASE + 32'hC;

  logic        clk;
  logic        RST_N;
  logic [7:0]  SRC_IN;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] RD_DATA;
  logic        RD_HIT;
  logic        INTR;

  logic        chk;
  int          checks;
  int          errors;

  int          kind_q [$];
  logic [31:0] exp_q  [$];
  string       name_q [$];

  iobus_intr_ctrl #(
    .N_SRC(8),
    .BASE_ADDR(BASE),
    .DB_CYCLES(4)
  ) dut (
    .clk(clk),
    .RST_N(RST_N),
    .SRC_IN(SRC_IN),
    .IOBUS_ADDR(IOBUS_ADDR),
    .IOBUS_OUT(IOBUS_OUT),
    .IOBUS_WR(IOBUS_WR),
    .RD_DATA(RD_DATA),
    .RD_HIT(RD_HIT),
    .INTR(INTR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor
  int          m_k;
  logic [31:0] m_e;
  logic [31:0] m_a;
  string       m_n;

  always @(negedge clk) begin
    if (chk) begin
      checks++;
      if (kind_q.size() == 0) begin
        errors++;
        $display("FAIL underflow: got check strobe, required queued entry");
      end else begin
        m_k = kind_q.pop_front();
        m_e = exp_q.pop_front();
        m_n = name_q.pop_front();
        case (m_k)
          0:       m_a = RD_DATA;
          1:       m_a = {31'd0, INTR};
          default: m_a = {31'd0, RD_HIT};
        endcase
        if (m_a !== m_e) begin
          errors++;
          $display("FAIL %s: got %h required %h", m_n, m_a, m_e);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    IOBUS_ADDR = a;
    IOBUS_OUT  = d;
    IOBUS_WR   = 1'b1;
    cyc(1);
    IOBUS_WR   = 1'b0;
  endtask

  task automatic push(input int k, input logic [31:0] e, input string n);
    kind_q.push_back(k);
    exp_q.push_back(e);
    name_q.push_back(n);
    chk = 1'b1;
    cyc(1);
    chk = 1'b0;
  endtask

  task automatic exp_rd(input logic [31:0] a, input logic [31:0] e,
                        input string n);
    IOBUS_ADDR = a;
    push(0, e, n);
  endtask

  task automatic exp_intr(input logic e, input string n);
    push(1, {31'd0, e}, n);
  endtask

  task automatic exp_hit(input logic [31:0] a, input logic e,
                         input string n);
    IOBUS_ADDR = a;
    push(2, {31'd0, e}, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    checks     = 0;
    errors     = 0;
    chk        = 1'b0;
    RST_N      = 1'b0;
    SRC_IN     = '0;
    IOBUS_ADDR = '0;
    IOBUS_OUT  = '0;
    IOBUS_WR   = 1'b0;
    cyc(3);
    RST_N = 1'b1;

    exp_rd(A_PND, 32'h0, "rst_pend");
    exp_rd(A_EN,  32'h0, "rst_en");
    exp_rd(A_CLM, 32'h0, "rst_claim");
    exp_rd(A_RAW, 32'h0, "rst_raw");
    exp_intr(1'b0, "rst_intr");
    exp_hit(A_CLM, 1'b1, "hit_base");
    exp_hit(BASE + 32'h10, 1'b0, "miss_hit");

    // 2-cycle pulse on src 3, masked
    SRC_IN = 8'h08;
    cyc(2);
    SRC_IN = 8'h00;
    exp_rd(A_RAW, 32'h08, "raw_src3");
    exp_rd(A_PND, 32'h08, "pend_src3");
    exp_rd(BASE + 32'h10, 32'h0, "miss_data");
    cyc(2);
    exp_intr(1'b0, "masked_intr");
    exp_rd(A_CLM, 32'h0, "masked_claim");

    // unmask, then W1C
    wr(A_EN, 32'h08);
    exp_intr(1'b0, "en_intr_e1");
    exp_intr(1'b1, "en_intr_e2");
    exp_rd(A_CLM, 32'h8000_0003, "claim_src3");
    wr(A_PND, 32'h08);
    exp_intr(1'b1, "w1c_intr_e0");
    exp_intr(1'b0, "w1c_intr_e1");
    exp_rd(A_PND, 32'h0, "w1c_pend");

    // simultaneous sources 1 and 5, held high
    wr(A_EN, 32'hFF);
    SRC_IN = 8'h22;
    cyc(3);
    exp_rd(A_CLM, 32'h8000_0001, "claim_src1");
    wr(A_PND, 32'h02);
    exp_rd(A_CLM, 32'h8000_0005, "claim_src5");
    exp_intr(1'b1, "intr_src5");
    exp_rd(A_PND, 32'h20, "sticky_held");
    SRC_IN = 8'h00;
    wr(A_PND, 32'h20);
    exp_rd(A_PND, 32'h0, "clr_src5");
    exp_intr(1'b0, "intr_idle");

    // W1C lands on the edge that registers the rise
    SRC_IN = 8'h04;
    cyc(2);
    wr(A_PND, 32'h04);
    exp_rd(A_PND, 32'h04, "set_wins");
    wr(A_PND, 32'h04);
    exp_rd(A_PND, 32'h0, "clr_src2");
    SRC_IN = 8'h00;

    // upper bits, ignored addr bits, read-only regs
    wr(A_EN, 32'hFFFF_FFFF);
    exp_rd(A_EN, 32'hFF, "en_upper");
    exp_rd(A_EN + 32'h3, 32'hFF, "addr_lsb");
    wr(A_CLM, 32'h0);
    wr(A_RAW, 32'h0);
    exp_rd(A_EN, 32'hFF, "ro_write");

    // async reset while everything is active
    SRC_IN = 8'hFF;
    cyc(4);
    exp_rd(A_PND, 32'hFF, "all_pend");
    exp_intr(1'b1, "all_intr");
    RST_N  = 1'b0;
    SRC_IN = 8'h80;
    exp_rd(A_PND, 32'h0, "async_pend");
    exp_intr(1'b0, "async_intr");
    exp_rd(A_EN, 32'h0, "async_en");
    RST_N = 1'b1;

    // source high across reset release
    cyc(2);
    exp_rd(A_PND, 32'h0, "rel_pend_e1");
    exp_rd(A_PND, 32'h80, "rel_pend_e2");
    exp_intr(1'b0, "rel_intr");
    SRC_IN = 8'h00;

    cyc(2);
    if (kind_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d left, required 0", kind_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
